// File: rtl/lvds_adc_pkg.sv
// Shared definitions for the LVDS sigma-delta ADC controller.
// Holds the FSM state encoding, the parameter defaults and the sample width rule.
package lvds_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2
    } adc_state_t;

    localparam int DEF_WINDOW_LOG2   = 8;
    localparam int DEF_SETTLE_CYCLES = 64;

    // A full window of ones equals 2^WINDOW_LOG2, which needs one extra bit.
    function automatic int data_width(input int window_log2);
        return window_log2 + 1;
    endfunction

endpackage

// File: rtl/lvds_adc_ctrl_if.sv
// Result handshake between the ADC controller (master) and its consumer (slave).
interface lvds_adc_ctrl_if
    import lvds_adc_pkg::*;
#(
    parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2
);

    logic [data_width(WINDOW_LOG2)-1:0] sample_data;
    logic                               sample_valid;
    logic                               sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/lvds_adc_accum.sv
// Decimation window counter and ones accumulator.
// win_end marks the last cycle of a window; win_sum already includes that cycle's bit.
module lvds_adc_accum
    import lvds_adc_pkg::*;
#(
    parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               run,
    input  logic                               comp_in,
    output logic                               win_end,
    output logic [data_width(WINDOW_LOG2)-1:0] win_sum
);

    localparam int DW = data_width(WINDOW_LOG2);

    logic [WINDOW_LOG2-1:0] win_cnt;
    logic [DW-1:0]          ones_acc;

    assign win_end = run && (win_cnt == {WINDOW_LOG2{1'b1}});
    assign win_sum = ones_acc + {{WINDOW_LOG2{1'b0}}, comp_in};

    // Dropping run clears everything, so each window starts from a fresh zero.
    always_ff @(posedge CLK) begin
        if (RST || !run) begin
            win_cnt  <= '0;
            ones_acc <= '0;
        end else if (win_end) begin
            win_cnt  <= '0;
            ones_acc <= '0;
        end else begin
            win_cnt  <= win_cnt + 1'b1;
            ones_acc <= win_sum;
        end
    end

endmodule

// File: rtl/lvds_adc_ctrl.sv
// LVDS sigma-delta ADC controller: settle/accumulate FSM, feedback drive,
// result handshake and sticky overrun reporting.
module lvds_adc_ctrl
    import lvds_adc_pkg::*;
#(
    parameter int WINDOW_LOG2   = DEF_WINDOW_LOG2,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic            stop,
    input  logic            continuous,
    input  logic            comp_in,
    output logic            fb_out,
    output logic            busy,
    output logic            overrun,
    input  logic            overrun_clr,
    lvds_adc_ctrl_if.master smp
);

    localparam int DW = data_width(WINDOW_LOG2);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    adc_state_t    state;
    adc_state_t    state_nxt;
    logic          accept;
    logic          cont_q;
    logic [SW-1:0] settle_cnt;
    logic          settle_done;
    logic          accum_run;
    logic          win_end;
    logic [DW-1:0] win_sum;
    logic          xfer;

    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign accum_run   = (state == ST_ACCUM) && !stop;
    assign xfer        = smp.sample_valid && smp.sample_ready;

    lvds_adc_accum #(
        .WINDOW_LOG2(WINDOW_LOG2)
    ) u_accum (
        .CLK     (CLK),
        .RST     (RST),
        .run     (accum_run),
        .comp_in (comp_in),
        .win_end (win_end),
        .win_sum (win_sum)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // stop takes priority everywhere, including over a simultaneous start in IDLE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    accept    = 1'b1;
                    state_nxt = (SETTLE_CYCLES == 0) ? ST_ACCUM : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (settle_done) begin
                    state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (win_end) begin
                    state_nxt = cont_q ? ST_ACCUM : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cont_q     <= 1'b0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            fb_out     <= 1'b0;
        end else begin
            if (accept) begin
                cont_q <= continuous;
            end
            settle_cnt <= ((state == ST_SETTLE) && (state_nxt == ST_SETTLE)) ? settle_cnt + 1'b1 : '0;
            busy       <= (state_nxt != ST_IDLE);
            fb_out     <= (state_nxt != ST_IDLE) && comp_in;
        end
    end

    // A finished window may load only if the holding register is free or being drained now.
    always_ff @(posedge CLK) begin
        if (RST) begin
            smp.sample_data  <= '0;
            smp.sample_valid <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            if (win_end) begin
                if (!smp.sample_valid || xfer) begin
                    smp.sample_data  <= win_sum;
                    smp.sample_valid <= 1'b1;
                end
            end else if (xfer) begin
                smp.sample_valid <= 1'b0;
            end

            if (win_end && smp.sample_valid && !xfer) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lvds_adc_ctrl.sv
// Self-checking bench for lvds_adc_ctrl (WINDOW_LOG2=4, SETTLE_CYCLES=3):
// directed scenarios followed by random traffic against a behavioural model.
module tb_lvds_adc_ctrl;

    localparam int WL2    = 4;
    localparam int SETTLE = 3;
    localparam int WIN    = 1 << WL2;

    logic CLK;
    logic RST;
    logic start;
    logic stop;
    logic continuous;
    logic comp_in;
    logic overrun_clr;
    logic fb_out;
    logic busy;
    logic overrun;

    lvds_adc_ctrl_if #(.WINDOW_LOG2(WL2)) smp_if ();

    lvds_adc_ctrl #(
        .WINDOW_LOG2   (WL2),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .stop        (stop),
        .continuous  (continuous),
        .comp_in     (comp_in),
        .fb_out      (fb_out),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .smp         (smp_if)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int check_count = 0;
    int pass_count  = 0;

    // Behavioural model: phase 0 idle, 1 settling, 2 accumulating; left = cycles remaining.
    int   m_phase = 0;
    int   m_left  = 0;
    int   m_sum   = 0;
    bit   m_cont  = 0;
    bit   m_busy  = 0;
    bit   m_fb    = 0;
    bit   m_valid = 0;
    bit   m_ovr   = 0;
    int   m_data  = 0;

    task automatic modelStep();
        bit xfer;
        bit load;
        int res;
        xfer = m_valid && smp_if.sample_ready;
        load = 0;
        res  = 0;
        if (RST) begin
            m_phase = 0; m_left = 0; m_sum = 0; m_cont = 0;
            m_busy = 0; m_fb = 0; m_valid = 0; m_ovr = 0; m_data = 0;
            return;
        end
        case (m_phase)
            0: if (start && !stop) begin
                m_cont = continuous;
                if (SETTLE > 0) begin
                    m_phase = 1; m_left = SETTLE;
                end else begin
                    m_phase = 2; m_left = WIN; m_sum = 0;
                end
            end
            1: if (stop) m_phase = 0;
               else begin
                   m_left--;
                   if (m_left == 0) begin
                       m_phase = 2; m_left = WIN; m_sum = 0;
                   end
               end
            default: if (stop) m_phase = 0;
               else begin
                   m_sum += int'(comp_in);
                   m_left--;
                   if (m_left == 0) begin
                       load = 1; res = m_sum;
                       if (m_cont) begin
                           m_left = WIN; m_sum = 0;
                       end else begin
                           m_phase = 0;
                       end
                   end
               end
        endcase
        if (load && m_valid && !xfer) m_ovr = 1;
        else if (overrun_clr) m_ovr = 0;
        if (load) begin
            if (!m_valid || xfer) begin
                m_data = res; m_valid = 1;
            end
        end else if (xfer) begin
            m_valid = 0;
        end
        m_busy = (m_phase != 0);
        m_fb   = m_busy && comp_in;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".busy"},   {31'd0, busy},                 {31'd0, m_busy});
        check({tag, ".fb_out"}, {31'd0, fb_out},               {31'd0, m_fb});
        check({tag, ".valid"},  {31'd0, smp_if.sample_valid},  {31'd0, m_valid});
        check({tag, ".data"},   {27'd0, smp_if.sample_data},   32'(m_data));
        check({tag, ".ovr"},    {31'd0, overrun},              {31'd0, m_ovr});
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic applyStimulus(input string tag);
        @(posedge CLK);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    task automatic drain();
        start = 0; stop = 1; smp_if.sample_ready = 1; overrun_clr = 1;
        applyStimulus("drain");
        stop = 0;
        applyStimulus("drain");
        smp_if.sample_ready = 0; overrun_clr = 0;
    endtask

    initial begin
        int first_rise;
        bit found;

        RST = 1; start = 0; stop = 0; continuous = 0; comp_in = 0;
        overrun_clr = 0; smp_if.sample_ready = 0;
        applyStimulus("reset");
        applyStimulus("reset");
        RST = 0;
        applyStimulus("idle");

        $display("[TB] single-shot, comp_in=1");
        comp_in = 1; start = 1;
        first_rise = 0;
        for (int e = 1; e <= 24; e++) begin
            applyStimulus("single");
            start = 0;
            if (smp_if.sample_valid && first_rise == 0) first_rise = e;
        end
        check("single.rise_edge", 32'(first_rise), 32'd20);
        check("single.data16", {27'd0, smp_if.sample_data}, 32'd16);
        check("single.idle", {31'd0, busy}, 32'd0);
        drain();

        $display("[TB] start and stop together in IDLE");
        start = 1; stop = 1;
        applyStimulus("startstop");
        start = 0; stop = 0;
        check("startstop.busy", {31'd0, busy}, 32'd0);
        applyStimulus("startstop");

        $display("[TB] continuous alternating pattern");
        continuous = 1; smp_if.sample_ready = 1; start = 1; comp_in = 1;
        for (int i = 0; i < SETTLE + 3 * WIN + 2; i++) begin
            applyStimulus("alt");
            start = 0;
            comp_in = ~comp_in;
            if (smp_if.sample_valid) check("alt.data8", {27'd0, smp_if.sample_data}, 32'd8);
        end
        check("alt.ovr", {31'd0, overrun}, 32'd0);
        drain();

        $display("[TB] overrun with consumer stalled");
        continuous = 1; comp_in = 1; start = 1;
        applyStimulus("ovr");
        start = 0;
        for (int i = 0; i < SETTLE + WIN; i++) applyStimulus("ovr");
        comp_in = 0;
        for (int i = 0; i < WIN; i++) applyStimulus("ovr");
        check("ovr.data16", {27'd0, smp_if.sample_data}, 32'd16);
        check("ovr.flag", {31'd0, overrun}, 32'd1);
        drain();

        $display("[TB] stop on sixth accumulate cycle");
        continuous = 0; comp_in = 1; start = 1;
        applyStimulus("stop");
        start = 0;
        for (int i = 0; i < SETTLE + 5; i++) applyStimulus("stop");
        stop = 1;
        applyStimulus("stop");
        stop = 0;
        check("stop.busy", {31'd0, busy}, 32'd0);
        check("stop.fb", {31'd0, fb_out}, 32'd0);
        for (int i = 0; i < WIN; i++) begin
            applyStimulus("stop");
            check("stop.novalid", {31'd0, smp_if.sample_valid}, 32'd0);
        end

        $display("[TB] ready pulsed on the load cycle");
        continuous = 1; start = 1;
        applyStimulus("same");
        start = 0;
        found = 0;
        for (int i = 0; i < SETTLE + 3 * WIN && !found; i++) begin
            comp_in = $urandom_range(0, 1);
            if (m_phase == 2 && m_left == 1 && m_valid) begin
                found = 1;
                smp_if.sample_ready = 1;
            end
            applyStimulus("same");
            smp_if.sample_ready = 0;
        end
        check("same.found", {31'd0, found}, 32'd1);
        check("same.valid", {31'd0, smp_if.sample_valid}, 32'd1);
        check("same.ovr", {31'd0, overrun}, 32'd0);
        drain();

        $display("[TB] reset mid-window with pending result and overrun");
        continuous = 1; comp_in = 1; start = 1;
        applyStimulus("rst");
        start = 0;
        for (int i = 0; i < SETTLE + 2 * WIN + 5; i++) applyStimulus("rst");
        check("rst.pre_valid", {31'd0, smp_if.sample_valid}, 32'd1);
        check("rst.pre_ovr", {31'd0, overrun}, 32'd1);
        RST = 1;
        applyStimulus("rst");
        RST = 0;
        check("rst.all_zero", {27'd0, smp_if.sample_data, smp_if.sample_valid, busy, fb_out, overrun}, 32'd0);
        continuous = 0; start = 1;
        applyStimulus("rst");
        start = 0;
        for (int i = 0; i < SETTLE + WIN; i++) applyStimulus("rst");
        check("rst.after_valid", {31'd0, smp_if.sample_valid}, 32'd1);
        check("rst.after_data", {27'd0, smp_if.sample_data}, 32'd16);
        drain();

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            RST                 = ($urandom_range(0, 199) == 0);
            start               = ($urandom_range(0, 9) == 0);
            stop                = ($urandom_range(0, 39) == 0);
            continuous          = $urandom_range(0, 1);
            comp_in             = $urandom_range(0, 1);
            smp_if.sample_ready = ($urandom_range(0, 3) == 0);
            overrun_clr         = ($urandom_range(0, 29) == 0);
            applyStimulus("rand");
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/lvds_adc_ctrl.md
LVDS_ADC_CTRL -- requirements
Module: lvds_adc_ctrl

Interface
REQ-001 Parameter WINDOW_LOG2, default 8: decimation window is 2^WINDOW_LOG2 cycles; legal range 2..16.
REQ-002 Parameter SETTLE_CYCLES, default 64: cycles discarded after start; 0 = no settle phase.
REQ-003 Port CLK, input, 1: single clock; every flop is on posedge CLK.
REQ-004 Port RST, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle pulse that begins a conversion; honoured only in IDLE.
REQ-006 Port stop, input, 1: one-cycle pulse that aborts any active conversion.
REQ-007 Port continuous, input, 1: mode select, sampled only on the cycle start is accepted.
REQ-008 Port comp_in, input, 1: LVDS comparator bit, already registered in the LVDS input cell.
REQ-009 Port fb_out, output, 1: registered feedback drive to the RC integrator pin.
REQ-010 Port sample_data, output, WINDOW_LOG2+1: count of ones in the last completed window.
REQ-011 Port sample_valid, output, 1: sample_data holds an unconsumed result.
REQ-012 Port sample_ready, input, 1: consumer accepts the result.
REQ-013 Port busy, output, 1: high in SETTLE or ACCUM.
REQ-014 Port overrun, output, 1: sticky flag, set when a result was dropped.
REQ-015 Port overrun_clr, input, 1: clears overrun.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE and ACCUM.
REQ-017 IDLE, start=1 -> SETTLE, or -> ACCUM directly when SETTLE_CYCLES=0; continuous latched on the same edge.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then -> ACCUM, with window counter and ones accumulator cleared.
REQ-019 ACCUM SHALL last exactly 2^WINDOW_LOG2 cycles; the accumulator adds comp_in each cycle, with width WINDOW_LOG2+1 and no saturation needed.
REQ-020 Last ACCUM cycle: the final sum, including that cycle's bit, SHALL load sample_data on the next edge, and sample_valid SHALL rise on the same edge.
REQ-021 End of window: latched continuous=1 -> ACCUM again with no gap cycle and a fresh accumulator; otherwise -> IDLE.
REQ-022 stop=1 in SETTLE or ACCUM -> IDLE next edge; the partial window is discarded and no sample_valid is produced.
REQ-023 stop and start both high in IDLE: stop wins, and the FSM stays IDLE.
REQ-024 In SETTLE and ACCUM, fb_out SHALL take comp_in at each edge; in IDLE, fb_out SHALL be 0.
REQ-025 A transfer occurs on a cycle with sample_valid=1 and sample_ready=1; sample_valid falls on the next edge unless a new result loads on that edge.
REQ-026 Result ready while sample_valid=1 and no transfer that cycle: the new result is dropped, sample_data is retained, and overrun is set.
REQ-027 Transfer and new-result load on the same cycle: the new result is loaded, sample_valid stays 1, and overrun is unchanged.
REQ-028 overrun_clr=1 clears overrun; if a set event occurs the same cycle, set wins.
REQ-029 A pending result (sample_valid=1) SHALL survive stop and return to IDLE until it is transferred.
REQ-030 busy SHALL be registered and equal (state != IDLE).

Reset
REQ-031 RST=1 at an edge: state=IDLE, fb_out=0, sample_data=0, sample_valid=0, busy=0, overrun=0, counters=0.
REQ-032 RST SHALL override every other input, including mid-window and with a pending result.

Structure
REQ-033 Shared package lvds_adc_pkg SHALL hold the state encoding, the WINDOW_LOG2/SETTLE_CYCLES defaults, and the data-width function WINDOW_LOG2+1.
REQ-034 One sub-module, lvds_adc_accum, SHALL hold the window counter, the ones accumulator and the end-of-window strobe; FSM, handshake and overrun logic stay in lvds_adc_ctrl.

Verification (WINDOW_LOG2=4, SETTLE_CYCLES=3 unless stated)
REQ-035 Scenario: comp_in=1 constant, single-shot start at edge 0 -> sample_valid rises at edge 20, sample_data=16, then IDLE with busy=0.
REQ-036 Scenario: comp_in alternating 1,0, continuous=1, sample_ready=1 -> sample_data=8 every 16 cycles, one-cycle valid pulses, overrun=0.
REQ-037 Scenario: continuous=1, sample_ready=0, window 1 comp_in=1 then window 2 comp_in=0 -> sample_data stays 16, and overrun=1 at the second window end.
REQ-038 Scenario: stop on the 6th ACCUM cycle -> next edge busy=0 and fb_out=0, with no sample_valid.
REQ-039 Scenario: continuous=1, sample_ready held 0 and pulsed exactly on the next window's last cycle -> sample_valid remains 1, new sample_data loads, overrun=0.
REQ-040 Scenario: RST mid-ACCUM with sample_valid=1 and overrun=1 -> every output is 0 after the reset edge; the next start gives a normal conversion.
